div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req_valid  input  NREQ  per-requester request valid.
REQ-006 i_req_divident  input  NREQ*WIDTH  dividends; requester k at bits [k*WIDTH +: WIDTH].
REQ-007 i_req_divisor  input  NREQ*WIDTH  divisors, same packing.
REQ-008 o_req_ready  output  NREQ  one-hot grant; the request is accepted when valid&ready.
REQ-009 o_rsp_valid  output  NREQ  one-hot result strobe to the originating requester.
REQ-010 o_rsp_quotient  output  WIDTH  shared quotient bus.
REQ-011 o_rsp_remainder  output  WIDTH  shared remainder bus.
REQ-012 o_rsp_div0  output  1  divide-by-zero flag for the current response.
REQ-013 i_drain  input  1  level; while high, no new grants are issued.
REQ-014 o_drained  output  1  high when in DRAIN with zero operations in flight.
REQ-015 o_busy  output  1  high when any operation is in flight.

Function
REQ-016 Block SHALL instantiate one unsigned pipelined divider, enable tied high, latency fixed at WIDTH+1 clocks from operand capture to result.
REQ-017 At most one grant per cycle; o_req_ready SHALL be combinational from i_req_valid, state and the round-robin pointer.
REQ-018 Round-robin: search starts at (last granted index + 1) mod NREQ; pointer updates only on an accepted request.
REQ-019 An accepted request's operands SHALL enter the divider in the same cycle; its requester index SHALL enter a WIDTH+1-deep tag/valid shift register.
REQ-020 o_rsp_valid bit k SHALL assert exactly WIDTH+1 cycles after acceptance from requester k, for one cycle; the response path has no backpressure.
REQ-021 Back-to-back grants SHALL yield back-to-back responses; throughput is 1 operation/cycle.
REQ-022 Divisor 0: o_rsp_div0=1, with quotient and remainder forced to 0; otherwise o_rsp_div0=0.
REQ-023 When o_rsp_valid is 0, the quotient, remainder and div0 outputs SHALL be 0.
REQ-024 FSM states IDLE, RUN and DRAIN. IDLE->RUN on any i_req_valid with i_drain low. RUN->IDLE when no requests and in-flight count is 0. Any state->DRAIN when i_drain rises. DRAIN->IDLE when i_drain falls.
REQ-025 In DRAIN, in-flight operations SHALL complete and respond normally; o_drained asserts the first cycle the in-flight count reaches 0.
REQ-026 The in-flight counter SHALL be WIDTH+1 capable. It increments on accept and decrements on response; simultaneous accept and response leave it unchanged.
REQ-027 A grant SHALL be issued in IDLE in the same cycle as the IDLE->RUN transition, with no idle bubble.

Reset
REQ-028 On reset: state IDLE, pointer set so requester 0 wins next, tag/valid pipeline cleared, counter 0, all outputs 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no o_rsp_valid after reset deasserts until a new grant plus WIDTH+1 cycles.

Configuration
REQ-030 Macro DIV_ARB_PRIO0_EN: when defined, requester 0 has strict priority over the round-robin among the others (pointer never lands on 0). When undefined, all NREQ requesters share pure round-robin.

Verification
REQ-031 Req0 with 100/7 accepted at cycle T -> o_rsp_valid=0001, q=14, r=2 at T+17; div0=0.
REQ-032 All four valid continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, starting 17 cycles later.
REQ-033 Req2 with 500/0 -> o_rsp_valid=0100, div0=1, q=0, r=0.
REQ-034 i_drain raised with 5 in flight while requests keep arriving -> no grants; 5 responses; o_drained asserts the cycle after the last response.
REQ-035 Reset asserted 3 cycles after 3 grants -> no responses ever appear for them; o_busy=0.
REQ-036 With DIV_ARB_PRIO0_EN, reqs 0 and 1 valid continuously -> req0 granted every cycle and req1 starved; without the macro they alternate.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one pipelined unsigned divider among NREQ requesters
// Ports: clk/reset (sync, active-high); i_req_valid/o_req_ready one-hot request handshake with
// packed i_req_divident/i_req_divisor operands; o_rsp_valid one-hot result strobe with shared
// o_rsp_quotient/o_rsp_remainder/o_rsp_div0; i_drain blocks new grants, o_drained reports an empty
// pipeline in DRAIN, o_busy reports any operation in flight.
// Option: define DIV_ARB_PRIO0_EN to give requester 0 strict priority over round-robin among the rest.
module div_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_divident,
  input  logic [NREQ*WIDTH-1:0] i_req_divisor,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_quotient,
  output logic [WIDTH-1:0]      o_rsp_remainder,
  output logic                  o_rsp_div0,
  input  logic                  i_drain,
  output logic                  o_drained,
  output logic                  o_busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    gnt_idx;
  logic             found, can_gnt, accept, rsp_v;
  int               cand;
  logic [WIDTH-1:0] div_a, div_b;
  // Stage 0 holds captured operands; stage s has resolved s quotient bits.
  logic [WIDTH-1:0] rem_q [WIDTH+1];
  logic [WIDTH-1:0] rem_d [WIDTH+1];
  logic [WIDTH-1:0] quo_q [WIDTH+1];
  logic [WIDTH-1:0] quo_d [WIDTH+1];
  logic [WIDTH-1:0] dvs_q [WIDTH+1];
  logic [WIDTH-1:0] dvs_d [WIDTH+1];
  logic [WIDTH:0]   part_d [WIDTH+1];
  logic [WIDTH:0]   z_q, z_d;
  logic [WIDTH:0]   tv_q, tv_d;
  logic [IW-1:0]    tag_q [WIDTH+1];
  logic [IW-1:0]    tag_d [WIDTH+1];
  assign can_gnt = !reset && !i_drain && state_q != S_DRAIN;
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
`ifdef DIV_ARB_PRIO0_EN
    found = i_req_valid[0];
    // The pointer cycles over 1..NREQ-1 only, so requester 0 is never part of the rotation.
    for (int i = 0; i < NREQ - 1; i++) begin
      cand = int'(ptr_q) + i >= NREQ ? int'(ptr_q) + i - (NREQ - 1) : int'(ptr_q) + i;
      if (!found && i_req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!found && i_req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
`endif
  end
  assign o_req_ready = can_gnt && found ? NREQ'(1) << gnt_idx : '0;
  assign accept      = |(i_req_valid & o_req_ready);
`ifdef DIV_ARB_PRIO0_EN
  assign ptr_d = accept && gnt_idx != '0 ? (gnt_idx == IW'(NREQ - 1) ? IW'(1) : gnt_idx + IW'(1)) : ptr_q;
`else
  assign ptr_d = accept ? (gnt_idx == IW'(NREQ - 1) ? '0 : gnt_idx + IW'(1)) : ptr_q;
`endif
  assign state_d = i_drain ? S_DRAIN :
                   state_q == S_DRAIN ? S_IDLE :
                   state_q == S_IDLE && |i_req_valid ? S_RUN :
                   state_q == S_RUN && !(|i_req_valid) && cnt_q == '0 ? S_IDLE : state_q;
  assign rsp_v = tv_q[WIDTH];
  assign cnt_d = cnt_q + CW'(accept) - CW'(rsp_v);
  assign div_a = accept ? i_req_divident[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
  assign div_b = accept ? i_req_divisor[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
  always_comb begin
    rem_d[0]  = '0;
    quo_d[0]  = div_a;
    dvs_d[0]  = div_b;
    part_d[0] = '0;
    z_d[0]    = div_b == '0;
    tag_d[0]  = gnt_idx;
    tv_d      = {tv_q[WIDTH-1:0], accept};
    // Restoring division: the dividend shifts out of quo's MSB into the partial remainder
    // while quotient bits shift in at the LSB.
    for (int s = 1; s <= WIDTH; s++) begin
      part_d[s] = {rem_q[s-1], quo_q[s-1][WIDTH-1]};
      rem_d[s]  = part_d[s] >= {1'b0, dvs_q[s-1]} ? WIDTH'(part_d[s] - {1'b0, dvs_q[s-1]}) : part_d[s][WIDTH-1:0];
      quo_d[s]  = {quo_q[s-1][WIDTH-2:0], part_d[s] >= {1'b0, dvs_q[s-1]}};
      dvs_d[s]  = dvs_q[s-1];
      z_d[s]    = z_q[s-1];
      tag_d[s]  = tag_q[s-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
`ifdef DIV_ARB_PRIO0_EN
      ptr_q   <= IW'(1);
`else
      ptr_q   <= '0;
`endif
      cnt_q   <= '0;
      tv_q    <= '0;
      z_q     <= '0;
      rem_q   <= '{default: '0};
      quo_q   <= '{default: '0};
      dvs_q   <= '{default: '0};
      tag_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
      z_q     <= z_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      tag_q   <= tag_d;
    end
  end
  assign o_rsp_valid     = rsp_v ? NREQ'(1) << tag_q[WIDTH] : '0;
  assign o_rsp_div0      = rsp_v && z_q[WIDTH];
  assign o_rsp_quotient  = rsp_v && !z_q[WIDTH] ? quo_q[WIDTH] : '0;
  assign o_rsp_remainder = rsp_v && !z_q[WIDTH] ? rem_q[WIDTH] : '0;
  assign o_drained       = state_q == S_DRAIN && cnt_q == '0;
  assign o_busy          = cnt_q != '0;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scoreboard bench for div_arbiter
module tb_div_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int LAT = W + 1;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] i_req_valid, o_req_ready, o_rsp_valid;
  logic [N*W-1:0] divd, divs;
  logic [W-1:0] o_rsp_quotient, o_rsp_remainder;
  logic o_rsp_div0, i_drain, o_drained, o_busy;
  div_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .reset(reset), .i_req_valid(i_req_valid), .i_req_divident(divd),
    .i_req_divisor(divs), .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid),
    .o_rsp_quotient(o_rsp_quotient), .o_rsp_remainder(o_rsp_remainder),
    .o_rsp_div0(o_rsp_div0), .i_drain(i_drain), .o_drained(o_drained), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0;
  int bad = 0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  typedef struct {
    int idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    int due;
  } exp_t;
  exp_t sb[$];
  exp_t m;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] g, input logic dr);
    exp_t e;
    @(posedge clk);
    #1;
    i_req_valid = v;
    i_drain = dr;
    for (int k = 0; k < N; k++) begin
      divd[k*W +: W] = opa[k];
      divs[k*W +: W] = opb[k];
    end
    @(negedge clk);
    chk("grant", 32'(o_req_ready), 32'(g));
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        e.idx = k;
        e.z = opb[k] == '0;
        e.q = e.z ? '0 : opa[k] / opb[k];
        e.r = e.z ? '0 : opa[k] % opb[k];
        e.due = cyc + LAT;
        sb.push_back(e);
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    i_req_valid = '0;
    i_drain = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(o_req_ready), 0);
    chk("rst_rsp", 32'(o_rsp_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_drained", 32'(o_drained), 0);
    chk("rst_data", 32'({o_rsp_div0, o_rsp_quotient | o_rsp_remainder}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        m = sb.pop_front();
        chk("rsp_valid", 32'(o_rsp_valid), 32'(1 << m.idx));
        chk("rsp_quot", 32'(o_rsp_quotient), 32'(m.q));
        chk("rsp_rem", 32'(o_rsp_remainder), 32'(m.r));
        chk("rsp_div0", 32'(o_rsp_div0), 32'(m.z));
      end else begin
        chk("rsp_idle_valid", 32'(o_rsp_valid), 0);
        chk("rsp_idle_data", 32'({o_rsp_div0, o_rsp_quotient | o_rsp_remainder}), 0);
      end
    end
  end
  logic [W-1:0] ea [6];
  logic [W-1:0] eb [6];
  logic [N-1:0] g;
  int last_due;
  initial begin
    reset = 1'b1;
    i_drain = 1'b0;
    i_req_valid = '0;
    divd = '0;
    divs = '0;
    for (int k = 0; k < N; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    do_reset();
    opa[0] = 16'd100;
    opb[0] = 16'd7;
    step(4'b0001, 4'b0001, 1'b0);
    idle(20);
    opa[2] = 16'd500;
    opb[2] = 16'd0;
    step(4'b0100, 4'b0100, 1'b0);
    idle(20);
    ea = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0005, 16'hFFFF, 16'h1234};
    eb = '{16'h0001, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h0002, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      opa[i%N] = ea[i];
      opb[i%N] = eb[i];
      g = N'(1) << (i % N);
      step(g, g, 1'b0);
    end
    idle(20);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) begin
        opa[k] = W'($urandom);
        opb[k] = W'($urandom_range(0, 300));
      end
`ifdef DIV_ARB_PRIO0_EN
      g = 4'b0001;
`else
      g = N'(1) << (i % N);
`endif
      step(4'b1111, g, 1'b0);
    end
    idle(20);
    for (int i = 0; i < 4; i++) step(4'b1010, i % 2 == 0 ? 4'b0010 : 4'b1000, 1'b0);
    step(4'b0110, 4'b0010, 1'b0);
    step(4'b0110, 4'b0100, 1'b0);
    step(4'b0110, 4'b0010, 1'b0);
    idle(20);
    for (int i = 0; i < 5; i++) begin
      opa[i%N] = W'(1000 + 77 * i);
      opb[i%N] = W'(3 + i);
      g = N'(1) << (i % N);
      step(g, g, 1'b0);
    end
    last_due = cyc + LAT;
    for (int i = 0; i < 22; i++) begin
      step(4'b1111, 4'b0000, 1'b1);
      chk("drained", 32'(o_drained), 32'(cyc > last_due));
      chk("busy_drain", 32'(o_busy), 32'(cyc <= last_due));
    end
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      g = N'(1) << i;
      step(g, g, 1'b0);
    end
    idle(2);
    do_reset();
    idle(25);
    chk("busy_after_rst", 32'(o_busy), 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      opa[0] = W'($urandom);
      opb[0] = W'($urandom_range(1, 500));
      opa[1] = W'($urandom);
      opb[1] = W'($urandom_range(1, 500));
`ifdef DIV_ARB_PRIO0_EN
      g = 4'b0001;
`else
      g = i % 2 == 0 ? 4'b0001 : 4'b0010;
`endif
      step(4'b0011, g, 1'b0);
    end
    idle(20);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
